// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// Provides the Booth digit encoder and the 3:2 carry-save compressor.
package booth_mul_pkg;

  localparam int WIDTH  = 32;
  localparam int PROD_W = 2 * WIDTH;
  // Multiplier is sign-extended by two bits, so one extra digit group exists.
  localparam int NUM_PP = WIDTH / 2 + 1;

  typedef struct packed {
    logic neg;
    logic one;
    logic two;
  } booth_digit_t;

  typedef logic [PROD_W-1:0] prod_t;

  typedef struct packed {
    prod_t sum;
    prod_t carry;
  } csa_t;

  // Group is {y[2i+1], y[2i], y[2i-1]}; 111 maps to zero with neg clear.
  function automatic booth_digit_t booth_encode(input logic [2:0] grp);
    booth_digit_t d;
    d = '0;
    case (grp)
      3'b001, 3'b010: d.one = 1'b1;
      3'b011:         d.two = 1'b1;
      3'b100:         begin d.neg = 1'b1; d.two = 1'b1; end
      3'b101, 3'b110: begin d.neg = 1'b1; d.one = 1'b1; end
      default:        d = '0;
    endcase
    return d;
  endfunction

  function automatic csa_t csa32(input prod_t a, input prod_t b, input prod_t c);
    csa_t r;
    r.sum   = a ^ b ^ c;
    r.carry = ((a & b) | (a & c) | (b & c)) << 1;
    return r;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth partial product: selects 0, +-x or +-2x, sign-extended to the product width.
// Negative rows are returned as one's complement; the caller adds the neg bit in the row LSB.
module booth_pp_gen
  import booth_mul_pkg::*;
(
  input  logic [2:0]       grp,
  input  logic [WIDTH-1:0] x,
  output prod_t            pp,
  output logic             neg
);

  booth_digit_t digit;
  prod_t        x_ext;
  prod_t        sel;

  always_comb begin
    digit = booth_encode(grp);
    x_ext = {{(PROD_W-WIDTH){x[WIDTH-1]}}, x};
    sel   = '0;
    if (digit.one) begin
      sel = x_ext;
    end else if (digit.two) begin
      sel = x_ext << 1;
    end
    pp  = digit.neg ? ~sel : sel;
    neg = digit.neg;
  end

endmodule

// File: rtl/booth_multiplier.sv
// Signed 32x32 radix-4 Booth multiplier, CSA tree into stage-1 registers, final add in stage 2.
// No valid/ready handshake: a new operand pair is taken every cycle and z follows two edges later.
module booth_multiplier
  import booth_mul_pkg::*;
(
  input  logic              mul_clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  x,
  input  logic [WIDTH-1:0]  y,
  output logic [PROD_W-1:0] z
);

  // Two sign bits on top keep y = 0x80000000 exact; the trailing zero is y[-1].
  logic [2*NUM_PP:0]  y_ext;
  prod_t              pp_raw [NUM_PP];
  logic [NUM_PP-1:0]  pp_neg;

  assign y_ext = {{2{y[WIDTH-1]}}, y, 1'b0};

  for (genvar i = 0; i < NUM_PP; i++) begin : g_pp
    booth_pp_gen u_pp (
      .grp (y_ext[2*i+2 -: 3]),
      .x   (x),
      .pp  (pp_raw[i]),
      .neg (pp_neg[i])
    );
  end

  // Wallace levels: 18 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2 rows.
  prod_t l0 [NUM_PP+1];
  prod_t l1 [12];
  prod_t l2 [8];
  prod_t l3 [6];
  prod_t l4 [4];
  prod_t l5 [3];
  prod_t sum_c;
  prod_t carry_c;
  csa_t  t;

  always_comb begin
    for (int i = 0; i < NUM_PP; i++) begin
      l0[i] = pp_raw[i] << (2 * i);
    end
    // The +1 of every negated row shares a single extra row.
    l0[NUM_PP] = '0;
    for (int i = 0; i < NUM_PP; i++) begin
      l0[NUM_PP][2*i] = pp_neg[i];
    end

    for (int g = 0; g < 6; g++) begin
      t = csa32(l0[3*g], l0[3*g+1], l0[3*g+2]);
      l1[2*g]   = t.sum;
      l1[2*g+1] = t.carry;
    end

    for (int g = 0; g < 4; g++) begin
      t = csa32(l1[3*g], l1[3*g+1], l1[3*g+2]);
      l2[2*g]   = t.sum;
      l2[2*g+1] = t.carry;
    end

    for (int g = 0; g < 2; g++) begin
      t = csa32(l2[3*g], l2[3*g+1], l2[3*g+2]);
      l3[2*g]   = t.sum;
      l3[2*g+1] = t.carry;
    end
    l3[4] = l2[6];
    l3[5] = l2[7];

    for (int g = 0; g < 2; g++) begin
      t = csa32(l3[3*g], l3[3*g+1], l3[3*g+2]);
      l4[2*g]   = t.sum;
      l4[2*g+1] = t.carry;
    end

    t = csa32(l4[0], l4[1], l4[2]);
    l5[0] = t.sum;
    l5[1] = t.carry;
    l5[2] = l4[3];

    t = csa32(l5[0], l5[1], l5[2]);
    sum_c   = t.sum;
    carry_c = t.carry;
  end

  prod_t sum_q;
  prod_t carry_q;

  // Carry out of the top bit is dropped; the exact product always fits.
  always_ff @(posedge mul_clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      carry_q <= '0;
      z       <= '0;
    end else begin
      sum_q   <= sum_c;
      carry_q <= carry_c;
      z       <= sum_q + carry_q;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed and short random checks for the two-stage signed Booth multiplier.
module tb_booth_multiplier;

  localparam int NVEC = 16;

  logic        mul_clk = 1'b0;
  logic        reset;
  logic [31:0] x;
  logic [31:0] y;
  logic [63:0] z;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];

  // Directed operands and hand-computed products.
  logic [31:0] vec_x [NVEC] = '{
    32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF,
    32'hFFFFFFFD, 32'h00000002, 32'hFFFFFFFC, 32'h00000000,
    32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF,
    32'h80000000, 32'h00010000, 32'h0000FFFF, 32'hFFFFFFFE
  };
  logic [31:0] vec_y [NVEC] = '{
    32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF,
    32'h00000005, 32'h00000003, 32'h00000007, 32'h12345678,
    32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF,
    32'h00000001, 32'h00010000, 32'h0000FFFF, 32'h40000000
  };
  logic [63:0] vec_z [NVEC] = '{
    64'h3FFFFFFF00000001, 64'h4000000000000000, 64'hC000000080000000, 64'h0000000000000001,
    64'hFFFFFFFFFFFFFFF1, 64'h0000000000000006, 64'hFFFFFFFFFFFFFFE4, 64'h0000000000000000,
    64'h0000000000000000, 64'h0000000080000000, 64'h0000000080000000, 64'hFFFFFFFF80000001,
    64'hFFFFFFFF80000000, 64'h0000000100000000, 64'h00000000FFFE0001, 64'hFFFFFFFF80000000
  };

  always #5 mul_clk = ~mul_clk;

  booth_multiplier dut (
    .mul_clk (mul_clk),
    .reset   (reset),
    .x       (x),
    .y       (y),
    .z       (z)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b);
    x = a;
    y = b;
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;

    // Reset state.
    reset = 1'b1;
    drive(32'h0, 32'h0);
    #23;
    check("reset_state", z, 64'h0);
    @(negedge mul_clk);
    reset = 1'b0;

    // Directed vectors back to back; z at negedge i reflects operands from negedge i-2.
    for (int i = 0; i < NVEC + 2; i++) begin
      @(negedge mul_clk);
      if (i >= 2) check($sformatf("directed_%0d", i - 2), z, vec_z[i-2]);
      if (i < NVEC) drive(vec_x[i], vec_y[i]);
      else drive(32'd5, 32'd7);
    end

    // Async reset with a nonzero result on z.
    @(negedge mul_clk);
    check("before_reset", z, 64'd35);
    #2;
    reset = 1'b1;
    #1;
    check("async_clear", z, 64'h0);
    drive(32'h0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge mul_clk);
      check($sformatf("reset_hold_%0d", i), z, 64'h0);
    end

    // Release and refill.
    reset = 1'b0;
    drive(32'd6, 32'd7);
    @(negedge mul_clk);
    check("refill_first", z, 64'h0);
    drive(32'hFFFFFFFD, 32'd5);
    @(negedge mul_clk);
    check("refill_second", z, 64'd42);
    @(negedge mul_clk);
    check("refill_third", z, 64'hFFFFFFFFFFFFFFF1);

    // Random operands with corner values mixed in.
    for (int k = 0; k < 600; k++) begin
      @(negedge mul_clk);
      if (k >= 2) check("random", z, exp_q.pop_front());
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: a = 32'h80000000;
        1: b = 32'h80000000;
        2: a = 32'hFFFFFFFF;
        3: b = 32'h0;
        default: ;
      endcase
      drive(a, b);
      exp_q.push_back(64'(longint'($signed(a)) * longint'($signed(b))));
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge mul_clk);
      check("random_drain", z, exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
